alu_opb_stage: RTL and testbench
================================

// Module: alu_opb_stage
// PURPOSE
//  Registered, parametrised operand-B select stage between register file/imm gen and the ALU.
//  Picks one of imm6, imm3, EX forward, MEM forward or register value, extends immediates to DATA_W.
//  Presents the result through a 2-entry valid/ready skid buffer, 1-cycle latency.
//  Replaces the combinational two-way operand mux and adds extension, forwarding, backpressure and flush.
// PARAMETERS
//  DATA_W   16  operand width; must be >= 8
//  IMM6_W    6  width of long immediate field
//  IMM3_W    3  width of short immediate field
//  REG_AW    3  register address width (forwarding compare)
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        synchronous active-low reset
//  flush          in   1        drop all buffered operands
//  in_valid       in   1        upstream operand request valid
//  in_ready       out  1        stage can accept (skid not full)
//  imm_Control_6  in   1        select long immediate
//  imm_Control_3  in   1        select short immediate
//  imm_signed     in   1        1 = sign-extend immediate, 0 = zero-extend
//  imm6           in   IMM6_W   raw long immediate
//  imm3           in   IMM3_W   raw short immediate
//  rs2_addr       in   REG_AW   source register of operand B
//  rs2ValueReg    in   DATA_W   register-file value
//  fwd_ex_valid   in   1        EX result writes back
//  fwd_ex_addr    in   REG_AW   EX destination
//  fwd_ex_data    in   DATA_W   EX result
//  fwd_mem_valid  in   1        MEM result writes back
//  fwd_mem_addr   in   REG_AW   MEM destination
//  fwd_mem_data   in   DATA_W   MEM result
//  out_valid      out  1        rs2Value valid to ALU
//  out_ready      in   1        ALU consumes operand
//  rs2Value       out  DATA_W   selected operand B
//  out_src        out  3        source code of rs2Value (pkg SRC_*)
//  sel_conflict   out  1        sticky: both imm controls seen high on an accepted request
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): out_valid=0, rs2Value=0, out_src=SRC_REG, sel_conflict=0, skid empty; in_ready=0 while rst_n=0, 1 first cycle after.
//  - Select priority: imm_Control_6 > imm_Control_3 > EX fwd > MEM fwd > rs2ValueReg.
//  - Forward hit: fwd_x_valid & fwd_x_addr==rs2_addr & rs2_addr!=0; register 0 never forwarded.
//  - Immediates: imm_signed=1 replicates MSB to DATA_W; 0 pads zeros.
//  - Both imm controls high: imm6 used, sel_conflict set; cleared only by reset.
//  - Accept = in_valid & in_ready; accepted operand appears at out_valid next cycle.
//  - Skid: entry0 drives outputs; entry1 fills when out_valid & !out_ready & accept. in_ready = !entry1_full.
//  - Simultaneous accept and consume with one entry: throughput 1/cycle, no bubble.
//  - Outputs hold stable while out_valid & !out_ready.
//  - flush: both entries invalidated next edge, out_valid=0; accept suppressed that cycle; flush beats accept.
//  - Reset mid-transfer discards all entries, no partial state kept.
// CONFIGURATION
//  OPB_FORWARD_EN defined: EX/MEM forwarding active as above.
//  Not defined: fwd_* ports present but ignored; sources SRC_FWD_EX/SRC_FWD_MEM never produced.
// STRUCTURE
//  Package alu_opb_pkg: SRC_REG=0, SRC_IMM6=1, SRC_IMM3=2, SRC_FWD_EX=3, SRC_FWD_MEM=4; src_t typedef.
//  Sub-module opb_skid_buf (DATA_W+3 payload, 2 entries, flush); select/extend logic stays in top.
// TESTING
//  1 imm6=6'b100001, imm_signed=1, ctrl6=1, out_ready=1 -> next cycle rs2Value=16'hFFE1, out_src=1.
//  2 imm3=3'b101, imm_signed=0, ctrl3=1 -> rs2Value=16'h0005, out_src=2.
//  3 rs2_addr=3, EX and MEM both hit (EX data 16'h1234, MEM 16'h5678) -> 16'h1234, out_src=3; rs2_addr=0 -> rs2ValueReg.
//  4 out_ready=0, three back-to-back valids -> two accepted, in_ready=0 on third; release -> in-order delivery, none lost.
//  5 both ctrls high -> imm6 chosen, sel_conflict=1 until rst_n=0.
//  6 flush with two entries buffered -> out_valid=0 next cycle, in_ready=1; reset mid-stall -> all outputs at reset values.

Source files
------------

// File: rtl/alu_opb_pkg.sv
// Shared source codes for the operand-B select stage.
// The codes travel with each buffered operand and appear on out_src.
package alu_opb_pkg;

    localparam int SRC_W = 3;

    typedef enum logic [SRC_W-1:0] {
        SRC_REG     = 3'd0,
        SRC_IMM6    = 3'd1,
        SRC_IMM3    = 3'd2,
        SRC_FWD_EX  = 3'd3,
        SRC_FWD_MEM = 3'd4
    } src_t;

endpackage

// File: rtl/opb_skid_buf.sv
// Two-entry valid/ready skid buffer with flush. Entry0 drives the outputs.
// Entry1 only fills when entry0 is stalled and a new word arrives.
module opb_skid_buf #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         v0, v1;
    logic [W-1:0] d0, d1;
    logic         accept, consume;

    assign in_ready  = !v1;
    assign accept    = in_valid && !v1 && !flush;
    assign consume   = v0 && out_ready;
    assign out_valid = v0;
    assign out_data  = d0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= '0;
        end else if (flush) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (consume || !v0) begin
            // Entry0 frees up this edge: promote entry1 first to keep order.
            if (v1) begin
                d0 <= d1;
                v1 <= accept;
            end else begin
                v0 <= accept;
                if (accept) d0 <= in_data;
            end
        end else if (accept) begin
            v1 <= 1'b1;
        end
    end

    // NOTE: the entry1 payload needs no reset; its valid bit alone decides whether it is ever read.
    always_ff @(posedge clk) begin
        if (accept && v0 && !(consume && !v1)) d1 <= in_data;
    end

endmodule

// File: rtl/alu_opb_stage.sv
// Registered operand-B select: immediates, EX/MEM forwarding, register value.
// Forwarding is compiled in only when OPB_FORWARD_EN is defined.
module alu_opb_stage
    import alu_opb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM6_W = 6,
    parameter int IMM3_W = 3,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              imm_Control_6,
    input  logic              imm_Control_3,
    input  logic              imm_signed,
    input  logic [IMM6_W-1:0] imm6,
    input  logic [IMM3_W-1:0] imm3,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rs2ValueReg,
    input  logic              fwd_ex_valid,
    input  logic [REG_AW-1:0] fwd_ex_addr,
    input  logic [DATA_W-1:0] fwd_ex_data,
    input  logic              fwd_mem_valid,
    input  logic [REG_AW-1:0] fwd_mem_addr,
    input  logic [DATA_W-1:0] fwd_mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rs2Value,
    output logic [2:0]        out_src,
    output logic              sel_conflict
);

    localparam int PAY_W = DATA_W + SRC_W;

    logic [DATA_W-1:0] imm6_ext, imm3_ext, sel_data;
    src_t              sel_src;
    logic              skid_ready, accept;
    logic [PAY_W-1:0]  out_payload;

    assign imm6_ext = imm_signed ? {{(DATA_W-IMM6_W){imm6[IMM6_W-1]}}, imm6}
                                 : {{(DATA_W-IMM6_W){1'b0}}, imm6};
    assign imm3_ext = imm_signed ? {{(DATA_W-IMM3_W){imm3[IMM3_W-1]}}, imm3}
                                 : {{(DATA_W-IMM3_W){1'b0}}, imm3};

`ifdef OPB_FORWARD_EN
    // Register 0 is hard-wired, so it is never a forwarding target.
    logic ex_hit, mem_hit;
    assign ex_hit  = fwd_ex_valid  && (fwd_ex_addr  == rs2_addr) && (rs2_addr != '0);
    assign mem_hit = fwd_mem_valid && (fwd_mem_addr == rs2_addr) && (rs2_addr != '0);
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                          fwd_mem_valid, fwd_mem_addr, fwd_mem_data, rs2_addr};
`endif

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        sel_src  = SRC_REG;
        sel_data = rs2ValueReg;
        if (imm_Control_6) begin
            sel_src  = SRC_IMM6;
            sel_data = imm6_ext;
        end else if (imm_Control_3) begin
            sel_src  = SRC_IMM3;
            sel_data = imm3_ext;
        end
`ifdef OPB_FORWARD_EN
        else if (ex_hit) begin
            sel_src  = SRC_FWD_EX;
            sel_data = fwd_ex_data;
        end else if (mem_hit) begin
            sel_src  = SRC_FWD_MEM;
            sel_data = fwd_mem_data;
        end
`endif
    end

    assign in_ready = rst_n && skid_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n)                                       sel_conflict <= 1'b0;
        else if (accept && imm_Control_6 && imm_Control_3) sel_conflict <= 1'b1;
    end

    opb_skid_buf #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (skid_ready),
        .in_data   ({sel_src, sel_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign rs2Value = out_payload[DATA_W-1:0];
    assign out_src  = out_payload[PAY_W-1:DATA_W];

endmodule

// File: tb/tb_alu_opb_stage.sv
// Directed self-checking bench for alu_opb_stage; expectations follow OPB_FORWARD_EN.
module tb_alu_opb_stage;

`ifdef OPB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic        imm_Control_6, imm_Control_3, imm_signed;
    logic [5:0]  imm6;
    logic [2:0]  imm3;
    logic [2:0]  rs2_addr;
    logic [15:0] rs2ValueReg;
    logic        fwd_ex_valid, fwd_mem_valid;
    logic [2:0]  fwd_ex_addr, fwd_mem_addr;
    logic [15:0] fwd_ex_data, fwd_mem_data;
    logic        out_valid, out_ready, sel_conflict;
    logic [15:0] rs2Value;
    logic [2:0]  out_src;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_opb_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .imm_Control_6 (imm_Control_6),
        .imm_Control_3 (imm_Control_3),
        .imm_signed    (imm_signed),
        .imm6          (imm6),
        .imm3          (imm3),
        .rs2_addr      (rs2_addr),
        .rs2ValueReg   (rs2ValueReg),
        .fwd_ex_valid  (fwd_ex_valid),
        .fwd_ex_addr   (fwd_ex_addr),
        .fwd_ex_data   (fwd_ex_data),
        .fwd_mem_valid (fwd_mem_valid),
        .fwd_mem_addr  (fwd_mem_addr),
        .fwd_mem_data  (fwd_mem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rs2Value      (rs2Value),
        .out_src       (out_src),
        .sel_conflict  (sel_conflict)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registered outputs are examined 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm_Control_6 = 1'b0; imm_Control_3 = 1'b0; imm_signed = 1'b0;
        imm6 = '0; imm3 = '0; rs2_addr = '0; rs2ValueReg = '0;
        fwd_ex_valid = 1'b0; fwd_ex_addr = '0; fwd_ex_data = '0;
        fwd_mem_valid = 1'b0; fwd_mem_addr = '0; fwd_mem_data = '0;

        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rs2Value", 32'(rs2Value), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_sel_conflict", 32'(sel_conflict), 32'd0);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Long immediate, sign-extended.
        in_valid = 1'b1; imm_Control_6 = 1'b1; imm6 = 6'b100001; imm_signed = 1'b1;
        tick();
        check("imm6_valid", 32'(out_valid), 32'd1);
        check("imm6_value", 32'(rs2Value), 32'hFFE1);
        check("imm6_src", 32'(out_src), 32'd1);
        check("imm6_no_conflict", 32'(sel_conflict), 32'd0);

        // Short immediate, zero-extended, back-to-back with the previous one.
        imm_Control_6 = 1'b0; imm_Control_3 = 1'b1; imm3 = 3'b101; imm_signed = 1'b0;
        tick();
        check("imm3_valid", 32'(out_valid), 32'd1);
        check("imm3_value", 32'(rs2Value), 32'h0005);
        check("imm3_src", 32'(out_src), 32'd2);

        // Both forwards hit: EX wins.
        imm_Control_3 = 1'b0; rs2_addr = 3'd3; rs2ValueReg = 16'hAAAA;
        fwd_ex_valid = 1'b1; fwd_ex_addr = 3'd3; fwd_ex_data = 16'h1234;
        fwd_mem_valid = 1'b1; fwd_mem_addr = 3'd3; fwd_mem_data = 16'h5678;
        tick();
        check("fwd_ex_value", 32'(rs2Value), FWD ? 32'h1234 : 32'hAAAA);
        check("fwd_ex_src", 32'(out_src), FWD ? 32'd3 : 32'd0);

        // Only MEM hits.
        fwd_ex_valid = 1'b0;
        tick();
        check("fwd_mem_value", 32'(rs2Value), FWD ? 32'h5678 : 32'hAAAA);
        check("fwd_mem_src", 32'(out_src), FWD ? 32'd4 : 32'd0);

        // Register 0 is never forwarded.
        fwd_ex_valid = 1'b1; fwd_ex_addr = 3'd0; fwd_mem_addr = 3'd0;
        rs2_addr = 3'd0; rs2ValueReg = 16'h0BEE;
        tick();
        check("r0_value", 32'(rs2Value), 32'h0BEE);
        check("r0_src", 32'(out_src), 32'd0);

        // Drain.
        fwd_ex_valid = 1'b0; fwd_mem_valid = 1'b0; in_valid = 1'b0;
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: three valids while stalled, only two accepted.
        out_ready = 1'b0; in_valid = 1'b1; rs2ValueReg = 16'h1111;
        #1 check("bp_ready_1", 32'(in_ready), 32'd1);
        tick();
        rs2ValueReg = 16'h2222;
        #1 check("bp_ready_2", 32'(in_ready), 32'd1);
        tick();
        rs2ValueReg = 16'h3333;
        #1 check("bp_ready_3", 32'(in_ready), 32'd0);
        tick();
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_value", 32'(rs2Value), 32'h1111);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_value", 32'(rs2Value), 32'h2222);
        tick();
        check("bp_third_dropped", 32'(out_valid), 32'd0);
        check("bp_ready_again", 32'(in_ready), 32'd1);

        // Both immediate controls: imm6 wins, conflict is sticky.
        in_valid = 1'b1; imm_Control_6 = 1'b1; imm_Control_3 = 1'b1;
        imm6 = 6'b011111; imm3 = 3'b111; imm_signed = 1'b1;
        tick();
        check("conflict_value", 32'(rs2Value), 32'h001F);
        check("conflict_src", 32'(out_src), 32'd1);
        check("conflict_set", 32'(sel_conflict), 32'd1);
        imm_Control_6 = 1'b0; imm_Control_3 = 1'b0; rs2ValueReg = 16'h0042;
        tick();
        check("conflict_sticky", 32'(sel_conflict), 32'd1);
        check("conflict_next_value", 32'(rs2Value), 32'h0042);

        // Fill both entries, then flush while a request is offered.
        out_ready = 1'b0; rs2ValueReg = 16'h4444;
        tick();
        check("full_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; rs2ValueReg = 16'h6666;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_keeps_conflict", 32'(sel_conflict), 32'd1);
        tick();
        check("flush_beats_accept", 32'(out_valid), 32'd0);

        // Reset while stalled with two entries.
        in_valid = 1'b1; rs2ValueReg = 16'h7777;
        tick();
        rs2ValueReg = 16'h8888;
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        #1 check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_rs2Value", 32'(rs2Value), 32'd0);
        check("midrst_out_src", 32'(out_src), 32'd0);
        check("midrst_sel_conflict", 32'(sel_conflict), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        check("midrst_no_stale", 32'(out_valid), 32'd0);
        in_valid = 1'b1; rs2ValueReg = 16'h9999;
        tick();
        check("post_rst_value", 32'(rs2Value), 32'h9999);
        check("post_rst_valid", 32'(out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
